// File: rtl/qdr_resp_pkg.sv
// Shared types for the QDRII+ burst-4 SRAM responder.
// Burst length, beat index width and sequencer state encoding.
package qdr_resp_pkg;

  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_e;

  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/qdr_sram_resp_if.sv
// qdriip_* bus between controller (master) and SRAM responder (slave).
// Commands, write data and masks flow to the slave; q/qvld flow back.
interface qdr_sram_resp_if #(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 18
);
  logic                  qdriip_dll_off_n;
  logic                  qdriip_r_n;
  logic                  qdriip_w_n;
  logic [ADDR_WIDTH-1:0] qdriip_sa;
  logic [DATA_WIDTH-1:0] qdriip_d;
  logic [BW_WIDTH-1:0]   qdriip_bw_n;
  logic [DATA_WIDTH-1:0] qdriip_q;
  logic                  qdriip_qvld;

  modport master (
    output qdriip_dll_off_n, qdriip_r_n, qdriip_w_n,
    output qdriip_sa, qdriip_d, qdriip_bw_n,
    input  qdriip_q, qdriip_qvld
  );

  modport slave (
    input  qdriip_dll_off_n, qdriip_r_n, qdriip_w_n,
    input  qdriip_sa, qdriip_d, qdriip_bw_n,
    output qdriip_q, qdriip_qvld
  );
endinterface

// File: rtl/qdr_resp_ram.sv
// Simple dual-port read-first array: 1 write port with per-lane enables,
// 1 read port with a registered (1-cycle) output.
module qdr_resp_ram #(
  parameter int DW = 36,
  parameter int BW = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [BW-1:0] we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int LW = DW / BW;

  logic [DW-1:0] mem [2**AW];

  // Non-blocking read and write on the same edge give old data
  always_ff @(posedge clk) begin
    if (re)
      rdata <= mem[raddr];
    for (int i = 0; i < BW; i++)
      if (we[i])
        mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
  end
endmodule

// File: rtl/qdr_sram_resp.sv
// QDRII+ burst-4 SRAM responder: write/read sequencers, RAM, read pipe.
// Ports: sys_clk, sys_rst (sync, low), bus (slave), status counters/error.
import qdr_resp_pkg::*;

module qdr_sram_resp #(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  qdr_sram_resp_if.slave      bus,
  output logic                protocol_err,
  output logic [15:0]         rd_burst_cnt,
  output logic [15:0]         wr_burst_cnt
);
  localparam int BA_W = MEM_AW - BEAT_W;
  localparam beat_t LAST = beat_t'(BURST_LEN - 1);

  seq_state_e wr_st, wr_nxt, rd_st, rd_nxt;
  beat_t             wr_beat, rd_beat;
  logic [BA_W-1:0]   wr_base, rd_base, sa_base;
  logic              cmd_w, cmd_r;
  logic              wr_acc, wr_act, wr_viol;
  logic              rd_acc, rd_act, rd_viol;
  logic [MEM_AW-1:0] waddr, raddr;
  logic [BW_WIDTH-1:0]   we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_sa;

  assign sa_base   = bus.qdriip_sa[BA_W-1:0];
  assign unused_sa = ^bus.qdriip_sa[ADDR_WIDTH-1:BA_W];

  // Reset also blocks acceptance so a held strobe is not counted
  assign cmd_w = !bus.qdriip_w_n && bus.qdriip_dll_off_n && sys_rst;
  assign cmd_r = !bus.qdriip_r_n && bus.qdriip_dll_off_n && sys_rst;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      wr_st   <= IDLE;
      rd_st   <= IDLE;
      wr_beat <= '0;
      rd_beat <= '0;
    end else begin
      wr_st <= wr_nxt;
      rd_st <= rd_nxt;
      if (wr_acc) begin
        wr_base <= sa_base;
        wr_beat <= beat_t'(1);
      end else if (wr_st == BURST) begin
        wr_beat <= wr_beat + beat_t'(1);
      end
      if (rd_acc) begin
        rd_base <= sa_base;
        rd_beat <= beat_t'(1);
      end else if (rd_st == BURST) begin
        rd_beat <= rd_beat + beat_t'(1);
      end
    end
  end

  always_comb begin
    wr_nxt = wr_st;
    rd_nxt = rd_st;
    unique case (wr_st)
      IDLE:  if (cmd_w) wr_nxt = BURST;
      BURST: if (wr_beat == LAST) wr_nxt = IDLE;
      default: wr_nxt = IDLE;
    endcase
    unique case (rd_st)
      IDLE:  if (cmd_r) rd_nxt = BURST;
      BURST: if (rd_beat == LAST) rd_nxt = IDLE;
      default: rd_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_acc  = (wr_st == IDLE) && cmd_w;
    wr_viol = (wr_st == BURST) && cmd_w;
    wr_act  = wr_acc || ((wr_st == BURST) && sys_rst);
    rd_acc  = (rd_st == IDLE) && cmd_r;
    rd_viol = (rd_st == BURST) && cmd_r;
    rd_act  = rd_acc || ((rd_st == BURST) && sys_rst);
    waddr   = wr_acc ? {sa_base, beat_t'(0)} : {wr_base, wr_beat};
    raddr   = rd_acc ? {sa_base, beat_t'(0)} : {rd_base, rd_beat};
    we      = wr_act ? ~bus.qdriip_bw_n : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      protocol_err <= 1'b0;
      rd_burst_cnt <= '0;
      wr_burst_cnt <= '0;
    end else begin
      if (rd_acc) rd_burst_cnt <= rd_burst_cnt + 16'd1;
      if (wr_acc) wr_burst_cnt <= wr_burst_cnt + 16'd1;
      if (rd_viol || wr_viol) protocol_err <= 1'b1;
    end
  end

  qdr_resp_ram #(
    .DW (DATA_WIDTH),
    .BW (BW_WIDTH),
    .AW (MEM_AW)
  ) u_ram (
    .clk   (sys_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.qdriip_d),
    .re    (rd_act),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // rd_v0 lines up with ram_q; the pipe plus the q register
  // adds RD_LATENCY stages after the RAM read edge.
  logic                  rd_v0;
  logic [RD_LATENCY-2:0] vpipe;
  logic [DATA_WIDTH-1:0] dpipe [RD_LATENCY-1];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      rd_v0           <= 1'b0;
      vpipe           <= '0;
      bus.qdriip_q    <= '0;
      bus.qdriip_qvld <= 1'b0;
    end else begin
      rd_v0    <= rd_act;
      vpipe[0] <= rd_v0;
      for (int i = 1; i < RD_LATENCY - 1; i++)
        vpipe[i] <= vpipe[i-1];
      bus.qdriip_qvld <= vpipe[RD_LATENCY-2];
      bus.qdriip_q    <= vpipe[RD_LATENCY-2] ?
                         dpipe[RD_LATENCY-2] : '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    dpipe[0] <= ram_q;
    for (int i = 1; i < RD_LATENCY - 1; i++)
      dpipe[i] <= dpipe[i-1];
  end
endmodule
